// File: rtl/hazard_ctrl.sv
// Hazard/interlock controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use/branch/HI-LO stalls, multi-cycle mult/div occupancy tracking and a stall counter.
module hazard_ctrl #(
    parameter int         MD_LATENCY = 32,
    parameter logic [1:0] LOAD_CODE  = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rsd,
    input  logic [4:0]  rtd,
    input  logic        branch,
    input  logic        j_src,
    input  logic        hilo_rd_d,
    input  logic        hilo_we_d,
    input  logic [4:0]  rse,
    input  logic [4:0]  rte,
    input  logic [4:0]  rf_wae,
    input  logic        we_rege,
    input  logic [1:0]  dm2rege,
    input  logic        hilo_wee,
    input  logic [4:0]  rf_wam,
    input  logic        we_regm,
    input  logic [1:0]  dm2regm,
    input  logic [4:0]  rf_waw,
    input  logic        we_regw,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_e,
    output logic        forward_ad,
    output logic        forward_bd,
    output logic [1:0]  forward_ae,
    output logic [1:0]  forward_be,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_overlap_err,
    output logic [31:0] stall_cnt
);
    localparam logic [5:0] MD_RELOAD = 6'(MD_LATENCY - 1);

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    md_state_e   md_state_q;
    logic [5:0]  md_cnt_q;
    logic        md_err_q;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    logic e_rs, e_rt, m_ld_rs, m_ld_rt, m_load;
    logic lwstall, brstall, mdstall, stall;

    assign e_rs    = we_rege && (rf_wae != 5'd0) && (rf_wae == rsd);
    assign e_rt    = we_rege && (rf_wae != 5'd0) && (rf_wae == rtd);
    assign m_load  = (dm2regm == LOAD_CODE) && we_regm && (rf_wam != 5'd0);
    assign m_ld_rs = m_load && (rf_wam == rsd);
    assign m_ld_rt = m_load && (rf_wam == rtd);

    assign lwstall = (dm2rege == LOAD_CODE) && (e_rs || e_rt);
    assign brstall = (branch && (e_rs || e_rt || m_ld_rs || m_ld_rt)) ||
                     (j_src && (e_rs || m_ld_rs));
    assign mdstall = md_busy && (hilo_rd_d || hilo_we_d);
    assign stall   = lwstall || brstall || mdstall;

    assign md_busy        = (md_state_q == MD_BUSY);
    assign md_done        = md_busy && (md_cnt_q == 6'd0);
    assign md_overlap_err = md_err_q;
    assign stall_cnt      = stall_cnt_q;

    // All pipeline controls are held inactive while reset is asserted.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_e    = 1'b0;
        forward_ad = 1'b0;
        forward_bd = 1'b0;
        forward_ae = 2'b00;
        forward_be = 2'b00;
        if (!rst) begin
            stall_f    = stall;
            stall_d    = stall;
            flush_e    = stall;
            forward_ad = (rsd != 5'd0) && we_regm && (rsd == rf_wam);
            forward_bd = (rtd != 5'd0) && we_regm && (rtd == rf_wam);
            if ((rse != 5'd0) && we_regm && (rse == rf_wam))
                forward_ae = 2'b10;
            else if ((rse != 5'd0) && we_regw && (rse == rf_waw))
                forward_ae = 2'b01;
            if ((rte != 5'd0) && we_regm && (rte == rf_wam))
                forward_be = 2'b10;
            else if ((rte != 5'd0) && we_regw && (rte == rf_waw))
                forward_be = 2'b01;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    // A start while busy restarts the count; the latest mult/div owns HI/LO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            md_state_q  <= MD_IDLE;
            md_cnt_q    <= 6'd0;
            md_err_q    <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            case (md_state_q)
                MD_IDLE: begin
                    if (hilo_wee) begin
                        md_state_q <= MD_BUSY;
                        md_cnt_q   <= MD_RELOAD;
                    end
                end
                MD_BUSY: begin
                    if (hilo_wee) begin
                        md_cnt_q <= MD_RELOAD;
                        md_err_q <= 1'b1;
                    end else if (md_cnt_q != 6'd0) begin
                        md_cnt_q <= md_cnt_q - 6'd1;
                    end else begin
                        md_state_q <= MD_IDLE;
                    end
                end
            endcase
        end
    end
endmodule
